// File: rtl/aoc_day1_cmd_parser.sv
// Parser for the Day 1 puzzle text: turns an ASCII stream such as
// "L68\nR48\n" into {direction, amount} rotation commands. It takes bytes
// over a valid/ready handshake and emits commands from a registered
// valid/ready output slot. Sticky flags report clamping, malformed input
// and clean end-of-file.
module aoc_day1_cmd_parser #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] cmd_data,
  output logic              cmd_dir_r,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [DATA_W-1:0] cmd_count,
  output logic              sat,
  output logic              err,
  output logic              done
);

  typedef enum logic [1:0] {S_DIR, S_NUM, S_DONE, S_ERR} state_t;

  localparam int WIDE_W = DATA_W + 4;

  state_t              state, state_next;
  logic [DATA_W-1:0]   acc;
  logic [3:0]          ndig;
  logic                dir;

  logic                accept;
  logic                is_ws, is_digit, is_l, is_r;
  logic [WIDE_W-1:0]   acc_wide;
  logic                acc_ovf;
  logic [DATA_W-1:0]   acc_new;

  // Decode flags produced by the next-state logic for the datapath.
  logic                start_line;
  logic                dig_step;
  logic                emit;

  assign accept   = in_valid && in_ready;
  assign is_ws    = (in_byte == 8'h0A) || (in_byte == 8'h0D) || (in_byte == 8'h20);
  assign is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
  assign is_l     = (in_byte == 8'h4C);
  assign is_r     = (in_byte == 8'h52);

  // acc*10 + digit with four guard bits, so the largest possible result
  // (all-ones * 10 + 9) still fits and overflow is just a nonzero top nibble.
  // For a digit the low nibble of the ASCII code is its value.
  assign acc_wide = ({4'b0, acc} * WIDE_W'(10)) + WIDE_W'(in_byte[3:0]);
  assign acc_ovf  = |acc_wide[WIDE_W-1:DATA_W];
  // Once clamped, all-ones times ten overflows again, so the clamp holds
  // for the rest of the line without a separate flag.
  assign acc_new  = acc_ovf ? '1 : acc_wide[DATA_W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= S_DIR;
    else     state <= state_next;
  end

  // Next-state and per-byte decode.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_next = state;
    start_line = 1'b0;
    dig_step   = 1'b0;
    emit       = 1'b0;
    unique case (state)
      S_DIR: if (accept) begin
        if (is_l || is_r) begin
          start_line = 1'b1;
          // A direction letter cannot end the file.
          state_next = in_last ? S_ERR : S_NUM;
        end else if (is_ws) begin
          state_next = in_last ? S_DONE : S_DIR;
        end else begin
          state_next = S_ERR;
        end
      end
      S_NUM: if (accept) begin
        if (is_digit) begin
          dig_step = 1'b1;
          // A final digit without a trailing newline still completes the line.
          if (in_last) begin
            emit       = 1'b1;
            state_next = S_DONE;
          end
        end else if (is_ws && (ndig != 4'd0)) begin
          emit       = 1'b1;
          state_next = in_last ? S_DONE : S_DIR;
        end else begin
          state_next = S_ERR;
        end
      end
      S_DONE:  state_next = S_DONE;
      default: state_next = S_ERR;
    endcase
  end

  // Outputs decoded from state: terminal states refuse input, and a byte is
  // only taken when the output slot is free or being drained this cycle.
  always_comb begin
    in_ready = ((state == S_DIR) || (state == S_NUM)) && (!cmd_valid || cmd_ready);
    done     = (state == S_DONE);
    err      = (state == S_ERR);
  end

  // Line accumulator and output command slot.
  always_ff @(posedge clk) begin
    // NOTE: every register here, including the output slot, is cleared on
    // reset so a partial line or held command cannot leak past it.
    if (rst) begin
      acc       <= '0;
      ndig      <= '0;
      dir       <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
      cmd_dir_r <= 1'b0;
      cmd_count <= '0;
      sat       <= 1'b0;
    end else begin
      if (start_line) begin
        dir  <= is_r;
        acc  <= '0;
        ndig <= '0;
      end
      if (dig_step) begin
        acc  <= acc_new;
        ndig <= (ndig == 4'hF) ? ndig : ndig + 4'd1;
        if (acc_ovf) sat <= 1'b1;
      end
      if (emit) begin
        cmd_valid <= 1'b1;
        // A final digit emits in the same edge it is accumulated.
        cmd_data  <= dig_step ? acc_new : acc;
        cmd_dir_r <= dir;
        cmd_count <= cmd_count + DATA_W'(1);
      end else if (cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aoc_day1_cmd_parser.sv
// Bench for aoc_day1_cmd_parser: table of whole-file streams with their
// expected commands and final flags, plus hand sequences for backpressure
// and reset. Expected commands go into a queue as stimulus is driven and
// are popped as the DUT hands each one over.
module tb_aoc_day1_cmd_parser;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_dir_r;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_count;
  logic              sat;
  logic              err;
  logic              done;

  aoc_day1_cmd_parser #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .cmd_data  (cmd_data),
    .cmd_dir_r (cmd_dir_r),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_count (cmd_count),
    .sat       (sat),
    .err       (err),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              dir;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef struct {
    string       txt;
    bit          last;
    int          n;
    logic [31:0] d0;
    bit          r0;
    logic [31:0] d1;
    bit          r1;
    int          count;
    bit          sat;
    bit          err;
    bit          done;
  } vec_t;

  cmd_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare each command at the cycle the consumer takes it.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_cmd: got dir=%0d data=%0h expected none", cmd_dir_r, cmd_data);
      end else begin
        cmd_t e;
        e = exp_q.pop_front();
        check("cmd_data", cmd_data, e.data);
        check("cmd_dir_r", cmd_dir_r, e.dir);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Present one byte and hold it until accepted; returns at accept edge + 1.
  task automatic send(input logic [7:0] b, input bit last);
    bit got;
    got = 1'b0;
    in_byte = b; in_valid = 1'b1; in_last = last;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        got = 1'b1;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("accept_timeout", got, 1'b1);
  endtask

  task automatic send_str(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) send(s[i], last && (i == s.len() - 1));
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  vec_t vecs[9];

  initial begin
    rst = 1'b1; in_byte = 8'h00; in_valid = 1'b0; in_last = 1'b0; cmd_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;

    // Reset state.
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_data", cmd_data, 0);
    check("rst_cmd_count", cmd_count, 0);
    check("rst_flags", {sat, err, done}, 0);
    check("rst_in_ready", in_ready, 1);

    vecs[0] = '{txt:"L68\nR48\n",          last:0, n:2, d0:68,           r0:0, d1:48, r1:1, count:2, sat:0, err:0, done:0};
    vecs[1] = '{txt:"R5\015\nL10",         last:1, n:2, d0:5,            r0:1, d1:10, r1:0, count:2, sat:0, err:0, done:1};
    vecs[2] = '{txt:"R99999999999\nL3\n",  last:0, n:2, d0:32'hFFFFFFFF, r0:1, d1:3,  r1:0, count:2, sat:1, err:0, done:0};
    vecs[3] = '{txt:"X",                   last:0, n:0, d0:0,            r0:0, d1:0,  r1:0, count:0, sat:0, err:1, done:0};
    vecs[4] = '{txt:"L\n",                 last:0, n:0, d0:0,            r0:0, d1:0,  r1:0, count:0, sat:0, err:1, done:0};
    vecs[5] = '{txt:"L5a",                 last:0, n:0, d0:0,            r0:0, d1:0,  r1:0, count:0, sat:0, err:1, done:0};
    vecs[6] = '{txt:"R0\nL007\n",          last:0, n:2, d0:0,            r0:1, d1:7,  r1:0, count:2, sat:0, err:0, done:0};
    vecs[7] = '{txt:" \nR1\n",             last:1, n:1, d0:1,            r0:1, d1:0,  r1:0, count:1, sat:0, err:0, done:1};
    vecs[8] = '{txt:"L2\n\n",              last:1, n:1, d0:2,            r0:0, d1:0,  r1:0, count:1, sat:0, err:0, done:1};

    for (int v = 0; v < 9; v++) begin
      do_reset();
      if (vecs[v].n > 0) exp_q.push_back('{dir: vecs[v].r0, data: vecs[v].d0});
      if (vecs[v].n > 1) exp_q.push_back('{dir: vecs[v].r1, data: vecs[v].d1});
      send_str(vecs[v].txt, vecs[v].last);
      settle();
      check($sformatf("v%0d_count", v), cmd_count, vecs[v].count);
      check($sformatf("v%0d_sat", v), sat, vecs[v].sat);
      check($sformatf("v%0d_err", v), err, vecs[v].err);
      check($sformatf("v%0d_done", v), done, vecs[v].done);
      check($sformatf("v%0d_in_ready", v), in_ready, !(vecs[v].err || vecs[v].done));
      check($sformatf("v%0d_pending", v), exp_q.size(), 0);
      exp_q.delete();
    end

    // Backpressure: held command stays stable and blocks input until taken.
    do_reset();
    cmd_ready = 1'b0;
    exp_q.push_back('{dir: 1'b0, data: 32'd1});
    exp_q.push_back('{dir: 1'b1, data: 32'd2});
    send_str("L1\n", 1'b0);
    check("bp_latency_valid", cmd_valid, 1);
    check("bp_in_ready_low", in_ready, 0);
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_data", {cmd_dir_r, cmd_data}, {1'b0, 32'd1});
      check("bp_hold_valid", cmd_valid, 1);
    end
    @(posedge clk); #1;
    cmd_ready = 1'b1;
    send_str("R2\n", 1'b0);
    settle();
    check("bp_count", cmd_count, 2);
    check("bp_pending", exp_q.size(), 0);
    exp_q.delete();

    // Reset with a held command, then reset mid-line.
    do_reset();
    cmd_ready = 1'b0;
    send_str("L9\n", 1'b0);
    check("rs_held", cmd_valid, 1);
    do_reset();
    check("rs_outputs", {cmd_valid, cmd_dir_r, sat, err, done}, 0);
    check("rs_cmd_data", cmd_data, 0);
    check("rs_cmd_count", cmd_count, 0);
    check("rs_in_ready", in_ready, 1);
    cmd_ready = 1'b1;
    send_str("R12", 1'b0);
    do_reset();
    exp_q.push_back('{dir: 1'b0, data: 32'd4});
    send_str("L4\n", 1'b0);
    settle();
    check("rs_count", cmd_count, 1);
    check("rs_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aoc_day1_cmd_parser.md
Name: aoc_day1_cmd_parser

Overview:
- Front-end that turns the raw Day 1 puzzle text into rotation commands for the dial solver.
- Consumes an ASCII byte stream ("L68\nR48\n...") over a valid/ready handshake.
- Emits one {direction, amount} command per line on a registered valid/ready output.
- Output pairs directly with the solver's in_data/dir_r inputs. A consumer without backpressure ties cmd_ready=1.

Parameters:
- DATA_W, 32, width of parsed amount and command counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_byte  in  8  ASCII character
- in_valid  in  1  in_byte valid
- in_last  in  1  marks final byte of file; qualified by in_valid&&in_ready
- in_ready  out  1  parser accepts byte this cycle
- cmd_data  out  DATA_W  parsed rotation amount
- cmd_dir_r  out  1  1=R (right), 0=L (left)
- cmd_valid  out  1  command held in output register
- cmd_ready  in  1  consumer takes command
- cmd_count  out  DATA_W  number of commands emitted
- sat  out  1  sticky: some amount exceeded 2^DATA_W-1 and was clamped
- err  out  1  sticky: malformed input seen
- done  out  1  sticky: in_last processed cleanly

Behaviour:
- Reset (sync, active-high): state=S_DIR, acc=0, ndig=0, dir=0. Outputs: cmd_valid=0, cmd_data=0, cmd_dir_r=0, cmd_count=0, sat=0, err=0, done=0. Any partial command and any held output are discarded.
- Byte accept: accept = in_valid && in_ready.
- in_ready = (state==S_DIR || state==S_NUM) && (!cmd_valid || cmd_ready). A terminator can therefore always be written to the output slot in the same cycle.
- Whitespace set: 0x0A, 0x0D, 0x20. Digits: 0x30..0x39.
- S_DIR, on accept:
  - 'L' (0x4C): dir=0, acc=0, ndig=0, go S_NUM.
  - 'R' (0x52): dir=1, acc=0, ndig=0, go S_NUM.
  - Whitespace: ignored, stay in S_DIR.
  - Anything else: go S_ERR.
- S_NUM, on accept:
  - Digit: acc = acc*10 + (byte-0x30), computed at DATA_W+4 bits. If the result exceeds 2^DATA_W-1, clamp acc to all-ones, set sat, and keep it clamped for the rest of the line. ndig increments, saturating.
  - Whitespace with ndig>0: emit the command, go S_DIR.
  - Whitespace with ndig==0: go S_ERR.
  - Anything else: go S_ERR.
- Emit: on the clock edge that accepts the terminator:
  - cmd_valid<=1, cmd_data<=acc, cmd_dir_r<=dir, cmd_count<=cmd_count+1.
  - Latency: 1 cycle from terminator accept to cmd_valid high.
  - For a digit byte with in_last, cmd_data includes that final digit.
- Output register: cmd_data and cmd_dir_r stay stable while cmd_valid && !cmd_ready. cmd_valid clears on cmd_ready unless a new emit occurs in the same cycle; a simultaneous pop and emit leaves cmd_valid=1 with the new data.
- in_last handling, applied to the accepted byte after normal processing:
  - Digit in S_NUM: emit and go S_DONE, so a file without a trailing newline is legal.
  - Terminator that emits: go S_DONE.
  - Whitespace in S_DIR: go S_DONE.
  - 'L'/'R', or a terminator with ndig==0: go S_ERR.
- S_DONE: done=1, in_ready=0. Stays until rst. A pending cmd_valid still drains.
- S_ERR: err=1, in_ready=0, no further emits. Stays until rst. A pending cmd_valid still drains.
- Amount "0" (e.g. "R0") is legal and emits cmd_data=0. Leading zeros are legal ("L007" emits 7).
- cmd_count wraps modulo 2^DATA_W.

Test Plan:
- Stream "L68\nR48\n" with cmd_ready=1 → two commands (0,68) then (1,48), each 1 cycle after its '\n' accept; cmd_count=2; done=0.
- Stream "R5\r\nL10" with in_last on '0' → (1,5), (0,10); the CRLF pair produces exactly one emit; done=1; in_ready=0 afterward.
- Hold cmd_ready=0 after the first emit while feeding "L1\nR2\n" → in_ready drops after '\n' #1; cmd_data stays 1 until cmd_ready; then (1,2) follows; no bytes lost.
- "R99999999999\n" (DATA_W=32) → cmd_data=0xFFFFFFFF, sat=1, err=0; a following "L3\n" emits (0,3) normally.
- Malformed inputs "X5\n", "L\n", "L5a" → err=1, in_ready=0, no command emitted for the bad line; cmd_count unchanged.
- Assert rst mid-line after "R12" with cmd_valid high → the next cycle has all outputs zero and state S_DIR; then "L4\n" emits (0,4) and cmd_count=1.
